// File: rtl/soc_io_pkg.sv
// Shared definitions for the SoC I/O bridge: register map, default window base
// and the active-low hex-to-7-segment encoder.
package soc_io_pkg;

  localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'hFFFF_F000;

  localparam logic [11:0] OFF_DIG   = 12'h000;
  localparam logic [11:0] OFF_MASK  = 12'h004;
  localparam logic [11:0] OFF_TIMER = 12'h020;
  localparam logic [11:0] OFF_LED   = 12'h060;
  localparam logic [11:0] OFF_SW    = 12'h070;
  localparam logic [11:0] OFF_BTN   = 12'h078;

  // Segment order {DP,G,F,E,D,C,B,A}, active-low, DP always off.
  function automatic logic [7:0] hex7seg(input logic [3:0] nib);
    logic [7:0] s;
    case (nib)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/soc_io_bridge_btn_debounce.sv
// Single-channel button conditioner: 2-flop synchroniser followed by a
// stability counter that accepts a new level after DEBOUNCE_CYC cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every output of a combinational block gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign btn_o = db_q;

endmodule

// File: rtl/soc_io_bridge.sv
// Address-decoding bridge between the core data port, DRAM and board I/O
// (LEDs, switches, buttons, scanned 7-segment display, free-running timer).
module soc_io_bridge
  import soc_io_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE  = PERIPH_BASE_DEFAULT,
  parameter int          DRAM_AW      = 14,
  parameter int          NUM_DIGITS   = 8,
  parameter int          LED_W        = 24,
  parameter int          SW_W         = 24,
  parameter int          BTN_W        = 5,
  parameter int          SCAN_DIV     = 50000,
  parameter int          DEBOUNCE_CYC = 100000
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_n,
  input  logic [31:0]           addr,
  input  logic                  we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic [DRAM_AW-1:0]    dram_a,
  output logic                  dram_we,
  input  logic [31:0]           dram_rdata,
  input  logic [SW_W-1:0]       sw,
  input  logic [BTN_W-1:0]      button,
  output logic [LED_W-1:0]      led,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic [7:0]            seg
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  periph_hit, periph_wr;
  logic [11:0]           off;
  logic [31:0]           periph_rd;
  logic [BTN_W-1:0]      btn_db;
  logic [3:0]            cur_nib;

  logic [31:0]           dig_data_q, dig_data_d;
  logic [NUM_DIGITS-1:0] dig_mask_q, dig_mask_d;
  logic [31:0]           timer_q, timer_d;
  logic [LED_W-1:0]      led_q, led_d;
  logic [SW_W-1:0]       sw_s1_q, sw_s2_q;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic [7:0]            seg_q, seg_d;

  assign periph_hit = (addr[31:12] == PERIPH_BASE[31:12]);
  assign periph_wr  = we & periph_hit;
  assign off        = addr[11:0] & 12'hFFC;
  assign dram_a     = addr[DRAM_AW+1:2];
  assign dram_we    = we & ~periph_hit;

  always_comb begin
    periph_rd = '0;
    case (off)
      OFF_DIG:   periph_rd = dig_data_q;
      OFF_MASK:  periph_rd[NUM_DIGITS-1:0] = dig_mask_q;
      OFF_TIMER: periph_rd = timer_q;
      OFF_LED:   periph_rd[LED_W-1:0] = led_q;
      OFF_SW:    periph_rd[SW_W-1:0] = sw_s2_q;
      OFF_BTN:   periph_rd[BTN_W-1:0] = btn_db;
      default:   periph_rd = '0;
    endcase
  end

  assign rdata = periph_hit ? periph_rd : dram_rdata;

  assign cur_nib = dig_data_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    dig_data_d = dig_data_q;
    dig_mask_d = dig_mask_q;
    led_d      = led_q;
    timer_d    = timer_q + 32'd1;
    if (periph_wr) begin
      case (off)
        OFF_DIG:   dig_data_d = wdata;
        OFF_MASK:  dig_mask_d = wdata[NUM_DIGITS-1:0];
        OFF_TIMER: timer_d    = wdata;
        OFF_LED:   led_d      = wdata[LED_W-1:0];
        default:   ;
      endcase
    end

    // The display samples the index held before this edge, so a data write
    // landing together with an index advance shows up on the next refresh.
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    dig_en_d = '1;
    if (!dig_mask_q[idx_q]) dig_en_d[idx_q] = 1'b0;
    seg_d = hex7seg(cur_nib);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      dig_data_q <= '0;
      dig_mask_q <= '0;
      timer_q    <= '0;
      led_q      <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      div_q      <= '0;
      idx_q      <= '0;
      dig_en_q   <= '1;
      seg_q      <= 8'hFF;
    end else begin
      dig_data_q <= dig_data_d;
      dig_mask_q <= dig_mask_d;
      timer_q    <= timer_d;
      led_q      <= led_d;
      sw_s1_q    <= sw;
      sw_s2_q    <= sw_s1_q;
      div_q      <= div_d;
      idx_q      <= idx_d;
      dig_en_q   <= dig_en_d;
      seg_q      <= seg_d;
    end
  end

  for (genvar g = 0; g < BTN_W; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_db (
      .clk  (cpu_clk),
      .rst_n(cpu_rst_n),
      .btn_i(button[g]),
      .btn_o(btn_db[g])
    );
  end

  assign led    = led_q;
  assign dig_en = dig_en_q;
  assign seg    = seg_q;

endmodule

// File: tb/tb_soc_io_bridge.sv
// Directed self-checking bench for soc_io_bridge with a fast scan divider and
// a short debounce time so every feature is reachable in a few hundred cycles.
module tb_soc_io_bridge;

  localparam logic [31:0] BASE = 32'hFFFF_F000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [13:0] dram_a;
  logic        dram_we;
  logic [31:0] dram_rdata = 32'hCAFE_BABE;
  logic [23:0] sw = '0;
  logic [4:0]  button = '0;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  soc_io_bridge #(
    .PERIPH_BASE (BASE),
    .DRAM_AW     (14),
    .NUM_DIGITS  (8),
    .LED_W       (24),
    .SW_W        (24),
    .BTN_W       (5),
    .SCAN_DIV    (4),
    .DEBOUNCE_CYC(8)
  ) dut (
    .cpu_clk   (clk),
    .cpu_rst_n (rst_n),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .dram_a    (dram_a),
    .dram_we   (dram_we),
    .dram_rdata(dram_rdata),
    .sw        (sw),
    .button    (button),
    .led       (led),
    .dig_en    (dig_en),
    .seg       (seg)
  );

  // Tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    addr  = BASE + 32'h020;
    repeat (3) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (rdata !== 32'h0) begin
        n_mis++;
        $display("FAIL reset_timer: got %h expected 00000000", rdata);
      end
      n_cmp++;
      if (led !== 24'h0 || dig_en !== 8'hFF || seg !== 8'hFF) begin
        n_mis++;
        $display("FAIL reset_outputs: led=%h dig_en=%h seg=%h expected 000000 FF FF", led, dig_en, seg);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dig_en !== 8'hFE || seg !== 8'hC0) begin
      n_mis++;
      $display("FAIL reset_release: dig_en=%h seg=%h expected FE C0", dig_en, seg);
    end
  endtask

  task automatic test_led();
    addr  = BASE + 32'h060;
    wdata = 32'h00AB_CDEF;
    we    = 1'b1;
    #1;
    n_cmp++;
    if (dram_we !== 1'b0) begin
      n_mis++;
      $display("FAIL led_dram_we: got %b expected 0", dram_we);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    n_cmp++;
    if (led !== 24'hAB_CDEF) begin
      n_mis++;
      $display("FAIL led_pins: got %h expected abcdef", led);
    end
    n_cmp++;
    if (rdata !== 32'h00AB_CDEF || dram_we !== 1'b0) begin
      n_mis++;
      $display("FAIL led_read: got %h dram_we=%b expected 00abcdef 0", rdata, dram_we);
    end
  endtask

  task automatic test_dram();
    addr  = 32'h0000_0010;
    wdata = 32'h1234_5678;
    we    = 1'b1;
    #1;
    n_cmp++;
    if (dram_we !== 1'b1 || dram_a !== 14'd4) begin
      n_mis++;
      $display("FAIL dram_store: dram_we=%b dram_a=%0d expected 1 4", dram_we, dram_a);
    end
    @(posedge clk);
    #1;
    we = 1'b0;
    n_cmp++;
    if (led !== 24'hAB_CDEF) begin
      n_mis++;
      $display("FAIL dram_led_untouched: got %h expected abcdef", led);
    end
    dram_rdata = 32'hCAFE_BABE;
    #1;
    n_cmp++;
    if (rdata !== 32'hCAFE_BABE) begin
      n_mis++;
      $display("FAIL dram_load: got %h expected cafebabe", rdata);
    end
  endtask

  task automatic test_unmapped();
    bus_write(BASE + 32'h010, 32'hFFFF_FFFF);
    addr = BASE + 32'h010;
    #1;
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_mis++;
      $display("FAIL unmapped_read: got %h expected 00000000", rdata);
    end
    bus_write(BASE + 32'h070, 32'hFFFF_FFFF);
    addr = BASE + 32'h070;
    #1;
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_mis++;
      $display("FAIL sw_ro_write: got %h expected 00000000", rdata);
    end
  endtask

  task automatic test_switches();
    sw   = 24'h5A_A5C3;
    addr = BASE + 32'h072;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_mis++;
      $display("FAIL sw_latency1: got %h expected 00000000", rdata);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (rdata !== 32'h005A_A5C3) begin
      n_mis++;
      $display("FAIL sw_latency2: got %h expected 005aa5c3", rdata);
    end
  endtask

  // Returns at the first cycle in which digit 0 becomes active again.
  task automatic wait_slot0(output logic ok);
    logic [7:0] prev;
    prev = dig_en;
    ok   = 1'b0;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (dig_en == 8'hFE && prev != 8'hFE) ok = 1'b1;
      prev = dig_en;
    end
    if (!ok) begin
      n_cmp++;
      n_mis++;
      $display("FAIL scan_timeout: dig_en=%h expected a return to FE", dig_en);
    end
  endtask

  task automatic test_scan();
    logic [7:0] exp_seg [8];
    logic       ok;
    // Standard active-low glyphs of nibbles 0,F,3,4,5,6,7,8 (low to high).
    exp_seg = '{8'hC0, 8'h8E, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    bus_write(BASE + 32'h000, 32'h8765_43F0);
    addr = BASE;
    #1;
    n_cmp++;
    if (rdata !== 32'h8765_43F0) begin
      n_mis++;
      $display("FAIL dig_readback: got %h expected 876543f0", rdata);
    end
    wait_slot0(ok);
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        logic [7:0] exp_en;
        exp_en    = 8'hFF;
        exp_en[i] = 1'b0;
        n_cmp++;
        if (dig_en !== exp_en || seg !== exp_seg[i]) begin
          n_mis++;
          $display("FAIL scan_slot%0d: dig_en=%h seg=%h expected %h %h", i, dig_en, seg, exp_en, exp_seg[i]);
        end
        repeat (4) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_mask();
    logic ok;
    bus_write(BASE + 32'h004, 32'h0000_0002);
    wait_slot0(ok);
    if (ok) begin
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (dig_en !== 8'hFF) begin
        n_mis++;
        $display("FAIL mask_slot1: got %h expected ff", dig_en);
      end
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (dig_en !== 8'hFB) begin
        n_mis++;
        $display("FAIL mask_slot2: got %h expected fb", dig_en);
      end
    end
    bus_write(BASE + 32'h004, 32'h0000_0000);
  endtask

  task automatic test_debounce();
    addr   = BASE + 32'h078;
    button = 5'b00100;
    repeat (5) @(posedge clk);
    #1;
    button = 5'b00000;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_mis++;
      $display("FAIL btn_glitch: got %h expected 00000000", rdata);
    end
    button = 5'b00100;
    repeat (9) @(posedge clk);
    #1;
    n_cmp++;
    if (rdata !== 32'h0) begin
      n_mis++;
      $display("FAIL btn_early: got %h expected 00000000", rdata);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (rdata !== 32'h0000_0004) begin
      n_mis++;
      $display("FAIL btn_accept: got %h expected 00000004", rdata);
    end
    button = 5'b00000;
  endtask

  task automatic test_timer();
    logic [31:0] exp_t [3];
    exp_t = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    bus_write(BASE + 32'h020, 32'hFFFF_FFFE);
    addr = BASE + 32'h020;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rdata !== exp_t[i]) begin
        n_mis++;
        $display("FAIL timer_seq%0d: got %h expected %h", i, rdata, exp_t[i]);
      end
      @(posedge clk);
      #1;
    end
    bus_write(BASE + 32'h020, 32'h0000_0100);
    addr = BASE + 32'h020;
    n_cmp++;
    if (rdata !== 32'h0000_0100) begin
      n_mis++;
      $display("FAIL timer_load_wins: got %h expected 00000100", rdata);
    end
  endtask

  task automatic test_async_reset();
    bus_write(BASE + 32'h060, 32'h0000_0055);
    addr = BASE + 32'h020;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (led !== 24'h0 || dig_en !== 8'hFF || seg !== 8'hFF || rdata !== 32'h0) begin
      n_mis++;
      $display("FAIL async_reset: led=%h dig_en=%h seg=%h timer=%h expected 000000 FF FF 00000000",
               led, dig_en, seg, rdata);
    end
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dig_en !== 8'hFE || seg !== 8'hC0) begin
      n_mis++;
      $display("FAIL async_reset_release: dig_en=%h seg=%h expected FE C0", dig_en, seg);
    end
  endtask

  initial begin
    test_reset();
    test_led();
    test_dram();
    test_unmapped();
    test_switches();
    test_scan();
    test_mask();
    test_debounce();
    test_timer();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
